// File: rtl/arinc429_tx.sv
// rtl/arinc429_tx.sv - ARINC 429 RZ bipolar transmitter with word FIFO
module arinc429_tx #(
    parameter int CLK_PER_BIT = 4,
    parameter int GAP_BITS    = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int PARITY_EN   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic        ovf_clr,
    output logic        line_A,
    output logic        line_B,
    output logic        busy,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        tx_done,
    output logic        overflow
);

    localparam int HALF     = CLK_PER_BIT / 2;
    localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int GAP_CLKS = GAP_BITS * CLK_PER_BIT;
    localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_BIT_HI   = 2'd1;
    localparam logic [1:0] ST_BIT_NULL = 2'd2;
    localparam logic [1:0] ST_GAP      = 2'd3;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [1:0]    state;
    logic [31:0]   shreg;
    logic [4:0]    bit_cnt;
    logic [CW-1:0] cell_cnt;
    logic [GW-1:0] gap_cnt;

    logic          cell_last;
    logic          gap_last;
    logic          pop;
    logic          push;
    logic [31:0]   head;
    logic [31:0]   ld_word;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign busy       = (state != ST_IDLE);

    assign cell_last = (cell_cnt == HALF_LAST);
    assign gap_last  = (gap_cnt == GAP_LAST);

    // A word is popped only when the line is free: from idle, or on the final gap clock.
    assign pop  = ((state == ST_IDLE) || ((state == ST_GAP) && gap_last)) && !fifo_empty;
    assign push = wr_en && (!fifo_full || pop);

    assign head    = mem[rd_ptr];
    assign ld_word = (PARITY_EN != 0) ? {~^head[30:0], head[30:0]} : head;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a new drop beats a clear).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (wr_en && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serialiser FSM: half cell driven, half cell null, then the inter-word gap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            cell_cnt <= '0;
            gap_cnt  <= '0;
            line_A   <= 1'b0;
            line_B   <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                shreg    <= ld_word;
                bit_cnt  <= '0;
                cell_cnt <= '0;
                state    <= ST_BIT_HI;
                line_A   <= ld_word[0];
                line_B   <= ~ld_word[0];
            end else begin
                case (state)
                    ST_BIT_HI: begin
                        if (cell_last) begin
                            cell_cnt <= '0;
                            state    <= ST_BIT_NULL;
                            line_A   <= 1'b0;
                            line_B   <= 1'b0;
                        end else begin
                            cell_cnt <= cell_cnt + 1'b1;
                        end
                    end
                    ST_BIT_NULL: begin
                        if (cell_last) begin
                            cell_cnt <= '0;
                            if (bit_cnt != 5'd31) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shreg   <= {1'b0, shreg[31:1]};
                                state   <= ST_BIT_HI;
                                line_A  <= shreg[1];
                                line_B  <= ~shreg[1];
                            end else begin
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                                tx_done <= 1'b1;
                            end
                        end else begin
                            cell_cnt <= cell_cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_last) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/arinc429_tx.md
Name: arinc429_tx

Overview:
- ARINC 429 transmitter, the transmit end of the RZ bipolar line that the six-channel receive top samples.
- Accepts 32-bit words from the host into a small FIFO.
- Serialises each word LSB-first onto a differential RZ pair (line_A/line_B), with an optional odd-parity bit and the mandatory inter-word gap.
- Runs on the same 400 kHz clock as the receivers (4 clocks per bit at 100 kbps).

Parameters:
- CLK_PER_BIT, 4, clocks per bit cell; must be even and >= 2.
- GAP_BITS, 4, null bit-times inserted after every word; >= 4 per ARINC 429.
- FIFO_DEPTH, 8, words of transmit buffering; power of 2.
- PARITY_EN, 1, 1 = replace bit 31 with odd parity over bits 30:0 at load; 0 = send bit 31 as written.

Ports:
- clock  in  1  system clock (400 kHz nominal)
- reset  in  1  asynchronous, active-high; clears all state
- wr_data  in  32  word to transmit; bit 0 goes on the line first, label bits are pre-ordered by the writer
- wr_en  in  1  write strobe, one word per cycle high
- ovf_clr  in  1  clears overflow
- line_A  out  1  RZ "high" leg
- line_B  out  1  RZ "low" leg
- busy  out  1  word on the line or in the gap
- fifo_full  out  1  FIFO holds FIFO_DEPTH words
- fifo_empty  out  1  FIFO holds 0 words
- tx_done  out  1  one-cycle pulse at the end of bit 31 of each word
- overflow  out  1  sticky; a write was dropped

Behaviour:
- Reset values:
  - line_A = line_B = 0.
  - busy = 0, tx_done = 0, overflow = 0.
  - fifo_empty = 1, fifo_full = 0.
  - FIFO pointers cleared.
  - FSM in IDLE.
- Line coding (registered outputs):
  - bit 1: A=1, B=0
  - bit 0: A=0, B=1
  - null: A=0, B=0
  - A=B=1 never occurs.
- Bit cell: first CLK_PER_BIT/2 clocks driven, remaining CLK_PER_BIT/2 clocks null.
- FSM states: IDLE, BIT_HI, BIT_NULL, GAP.
  - IDLE:
    - If the FIFO is non-empty at a clock edge: pop the word, load the shift register (parity applied if PARITY_EN), zero the bit counter, enter BIT_HI and drive bit 0 on that same edge.
    - Latency: a write on edge N into an empty FIFO with the FSM idle appears on the lines at edge N+1.
  - BIT_HI:
    - Hold CLK_PER_BIT/2 clocks, then go to BIT_NULL with lines null.
  - BIT_NULL:
    - Hold CLK_PER_BIT/2 clocks.
    - If the bit counter is below 31: increment it, shift, and return to BIT_HI driving the next bit.
    - If the bit counter = 31: go to GAP and pulse tx_done on that transition cycle.
  - GAP:
    - Lines null for GAP_BITS*CLK_PER_BIT clocks.
    - On the last gap clock: if the FIFO is non-empty, pop and enter BIT_HI directly (same as IDLE); otherwise go to IDLE.
- Word period: (32+GAP_BITS)*CLK_PER_BIT clocks, which is 144 at the defaults.
- busy = 1 in BIT_HI, BIT_NULL and GAP.
- Parity: bit 31 = ~^wr_data[30:0], computed at pop, so the total number of ones is odd.
- FIFO writes:
  - Accepted when not full.
  - Accepted when full only if a pop happens on the same edge; the count is then unchanged.
  - Write to an empty FIFO with the FSM ready to pop on the same edge: word enters the FIFO and is popped next eligible edge; no bypass.
- Overflow: a write to a full FIFO with no simultaneous pop is dropped and sets overflow.
  - ovf_clr clears overflow; if ovf_clr and a new overflow event coincide, set wins.
- Reset mid-word: lines go null immediately (asynchronous), the partial word is abandoned and the FIFO contents are discarded.
- Counters wrap-free: the bit counter is 5 bits, and cell/gap counters are sized by $clog2 of their maximum.

Test Plan:
- Reset, then single write 0x0000_0001 with PARITY_EN=1:
  - Line starts 1 cycle after the write.
  - Bit 0 gives A=1 for 2 clocks then null for 2.
  - Bits 1–30 give B=1 pulses.
  - Bit 31 = 0 (B pulse), since there is one 1 → odd already.
  - tx_done pulses at clock 128 after line start.
  - busy falls at clock 144.
- Write 0x0000_0000 with PARITY_EN=1 → bit 31 transmitted as 1 (A pulse on the last cell); with PARITY_EN=0 → B pulse.
- Burst of 3 words back-to-back:
  - Word start edges are spaced exactly 144 clocks apart.
  - Each gap shows 16 null clocks.
  - busy stays 1 throughout.
  - fifo_empty rises at the third pop.
- 9 writes in consecutive cycles with the FSM idle at the start:
  - The first is popped at once, so all 9 fit (8 in the FIFO).
  - A 10th write sets overflow and the word is lost.
  - fifo_full = 1 until the next pop.
  - ovf_clr clears overflow.
- Write while full on the exact pop edge → accepted, no overflow, count stays 8.
- Assert reset at bit 17 of a word:
  - Lines read 0/0 within the same cycle.
  - fifo_empty = 1.
  - After release, nothing is transmitted until a new write.
